// File: rtl/afvip_intr_ctrl_if.sv
// Single-cycle register access port between the APB slave decode and afvip_intr_ctrl.
interface afvip_intr_ctrl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    // Register decode side: issues strobes, address and write data.
    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    // Interrupt controller side: accepts accesses, returns registered read data.
    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/afvip_intr_ctrl.sv
// Interrupt source for the AFVIP interrupt monitor: edge-detected sticky status,
// per-source mask, registered level interrupt and a saturating assertion counter.
module afvip_intr_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   evt_i,
    afvip_intr_ctrl_if.slave     bus,
    output logic                 afvip_intr
);

    localparam logic [1:0]       ADDR_STATUS = 2'd0;
    localparam logic [1:0]       ADDR_MASK   = 2'd1;
    localparam logic [1:0]       ADDR_SET    = 2'd2;
    localparam logic [1:0]       ADDR_COUNT  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [NUM_SRC-1:0] evt_q;
    logic [NUM_SRC-1:0] status_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        rdata_q;

    logic [NUM_SRC-1:0] evt_rise;
    logic [NUM_SRC-1:0] wdata_src;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] status_next;
    logic [NUM_SRC-1:0] mask_next;
    logic [CNT_W-1:0]   count_next;
    logic [31:0]        rdata_next;
    logic               intr_next;
    logic               wr_status;
    logic               wr_mask;
    logic               wr_set;
    logic               wr_count;

    // Write-data bits beyond the source/counter width are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus.reg_wdata;

    assign bus.reg_rdata = rdata_q;

    // Next-state for all registers; set beats W1C, and the interrupt sees same-cycle updates.
    always_comb begin
        evt_rise    = evt_i & ~evt_q;
        wdata_src   = bus.reg_wdata[NUM_SRC-1:0];
        wr_status   = bus.reg_wr && (bus.reg_addr == ADDR_STATUS);
        wr_mask     = bus.reg_wr && (bus.reg_addr == ADDR_MASK);
        wr_set      = bus.reg_wr && (bus.reg_addr == ADDR_SET);
        wr_count    = bus.reg_wr && (bus.reg_addr == ADDR_COUNT);

        set_vec     = evt_rise | (wr_set ? wdata_src : '0);
        clr_vec     = wr_status ? wdata_src : '0;
        status_next = set_vec | (status_q & ~clr_vec);
        mask_next   = wr_mask ? wdata_src : mask_q;
        intr_next   = |(status_next & mask_next);

        count_next = count_q;
        if (wr_count) begin
            count_next = '0;
        end else if (intr_next && !afvip_intr && (count_q != CNT_MAX)) begin
            count_next = count_q + CNT_W'(1);
        end

        // Read data is taken from pre-write values so a simultaneous write is not visible.
        rdata_next = rdata_q;
        if (bus.reg_rd) begin
            case (bus.reg_addr)
                ADDR_STATUS: rdata_next = 32'(status_q);
                ADDR_MASK:   rdata_next = 32'(mask_q);
                ADDR_SET:    rdata_next = '0;
                ADDR_COUNT:  rdata_next = 32'(count_q);
                default:     rdata_next = '0;
            endcase
        end
    end

    // State registers; reset discards any access or event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q      <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            afvip_intr <= 1'b0;
        end else begin
            evt_q      <= evt_i;
            status_q   <= status_next;
            mask_q     <= mask_next;
            count_q    <= count_next;
            rdata_q    <= rdata_next;
            afvip_intr <= intr_next;
        end
    end

endmodule

// File: tb/tb_afvip_intr_ctrl.sv
// Bench for afvip_intr_ctrl: directed scenarios plus random traffic against a
// per-bit reference model of the register/interrupt rules.
module tb_afvip_intr_ctrl;

    localparam int unsigned NSRC  = 8;
    localparam int unsigned CW    = 8;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] evt;
    logic            intr;

    afvip_intr_ctrl_if bus ();

    afvip_intr_ctrl #(
        .NUM_SRC (NSRC),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_i      (evt),
        .bus        (bus.slave),
        .afvip_intr (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    // Reference model state
    bit          m_prev  [NSRC];
    bit          m_stat  [NSRC];
    bit          m_mask  [NSRC];
    int unsigned m_count;
    bit          m_intr;
    logic [31:0] m_rdata;
    logic [NSRC-1:0] evt_lvl;

    function automatic logic [31:0] pack_bits(input bit v [NSRC]);
        logic [31:0] r = '0;
        for (int i = 0; i < NSRC; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    // Apply the rules of one clock edge to the model.
    task automatic model_edge(input logic r, input logic [NSRC-1:0] e, input logic w,
                              input logic rd, input logic [1:0] a, input logic [31:0] d);
        bit any_pending;
        if (r) begin
            for (int i = 0; i < NSRC; i++) begin
                m_prev[i] = 0; m_stat[i] = 0; m_mask[i] = 0;
            end
            m_count = 0; m_intr = 0; m_rdata = '0;
            return;
        end
        if (rd) begin
            if (a == 2'd0)      m_rdata = pack_bits(m_stat);
            else if (a == 2'd1) m_rdata = pack_bits(m_mask);
            else if (a == 2'd2) m_rdata = '0;
            else                m_rdata = 32'(m_count);
        end
        any_pending = 0;
        for (int i = 0; i < NSRC; i++) begin
            bit event_seen = e[i] && !m_prev[i];
            bit sw_set     = w && (a == 2'd2) && d[i];
            bit sw_clear   = w && (a == 2'd0) && d[i];
            if (event_seen || sw_set) m_stat[i] = 1;
            else if (sw_clear)        m_stat[i] = 0;
            if (w && (a == 2'd1)) m_mask[i] = d[i];
            m_prev[i] = e[i];
            if (m_stat[i] && m_mask[i]) any_pending = 1;
        end
        if (w && (a == 2'd3))                          m_count = 0;
        else if (any_pending && !m_intr && m_count < CMAX) m_count++;
        m_intr = any_pending;
    endtask

    // Drive one cycle, advance the model, then sample just after the edge.
    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [1:0] a, input logic [31:0] d);
        rst = r; evt = evt_lvl;
        bus.reg_wr = w; bus.reg_rd = rd; bus.reg_addr = a; bus.reg_wdata = d;
        model_edge(r, evt_lvl, w, rd, a, d);
        @(posedge clk);
        #1;
        chk("intr", 32'(intr), 32'(m_intr));
        chk("rdata", bus.reg_rdata, m_rdata);
        bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    endtask

    task automatic idle();                                step(1'b0, 1'b0, 1'b0, 2'd0, '0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1'b0, 1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [1:0] a);               step(1'b0, 1'b0, 1'b1, a, '0);   endtask

    int unsigned cnt_before;

    initial begin
        rst = 1'b1; evt = '0; evt_lvl = '0;
        bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;

        // Reset with all sources high; accesses during reset are discarded.
        phase = "reset";
        evt_lvl = 8'hFF;
        step(1'b1, 1'b1, 1'b1, 2'd1, 32'hFF);
        step(1'b1, 1'b0, 1'b1, 2'd0, '0);
        chk("intr_in_reset", 32'(intr), 32'd0);
        chk("rdata_in_reset", bus.reg_rdata, 32'd0);
        idle();
        chk("intr_masked_after_release", 32'(intr), 32'd0);
        rd(2'd0); chk("status_ff", bus.reg_rdata, 32'hFF);
        rd(2'd1); chk("mask_zero", bus.reg_rdata, 32'h0);
        rd(2'd3); chk("count_zero", bus.reg_rdata, 32'h0);
        rd(2'd2); chk("set_reads_zero", bus.reg_rdata, 32'h0);
        evt_lvl = '0;
        wr(2'd0, 32'hFF);

        // Basic path
        phase = "basic";
        wr(2'd1, 32'h01);
        evt_lvl = 8'h01; idle();
        chk("intr_on_event", 32'(intr), 32'd1);
        evt_lvl = 8'h00; rd(2'd0);
        chk("status_bit0", bus.reg_rdata, 32'h01);
        rd(2'd3); chk("count_one", bus.reg_rdata, 32'd1);
        wr(2'd0, 32'h01);
        chk("intr_cleared", 32'(intr), 32'd0);

        // Masking
        phase = "mask";
        wr(2'd1, 32'h00);
        evt_lvl = 8'h08; idle();
        chk("intr_masked", 32'(intr), 32'd0);
        evt_lvl = 8'h00; rd(2'd0);
        chk("status_bit3", bus.reg_rdata, 32'h08);
        wr(2'd1, 32'h08);
        chk("intr_unmasked", 32'(intr), 32'd1);
        rd(2'd3); chk("count_two", bus.reg_rdata, 32'd2);
        wr(2'd0, 32'h08);

        // Collision of event and W1C on the same bit
        phase = "collision";
        wr(2'd1, 32'h04);
        evt_lvl = 8'h04; idle();
        evt_lvl = 8'h00; idle();
        rd(2'd3); cnt_before = bus.reg_rdata;
        evt_lvl = 8'h04; wr(2'd0, 32'h04);
        chk("intr_held", 32'(intr), 32'd1);
        evt_lvl = 8'h00; rd(2'd0);
        chk("status_bit2", bus.reg_rdata, 32'h04);
        rd(2'd3); chk("count_no_inc", bus.reg_rdata, cnt_before);
        wr(2'd0, 32'h04);

        // Level hold gives a single event
        phase = "level";
        wr(2'd1, 32'h20);
        evt_lvl = 8'h20;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) wr(2'd0, 32'h20);
            else        idle();
        end
        rd(2'd0); chk("status5_stays_clear", bus.reg_rdata, 32'h00);
        evt_lvl = 8'h00; idle();
        evt_lvl = 8'h20; idle();
        rd(2'd0); chk("status5_retrigger", bus.reg_rdata, 32'h20);
        evt_lvl = 8'h00; wr(2'd0, 32'h20);

        // Simultaneous read and write returns the old value
        phase = "rdwr";
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h5A);
        chk("old_mask", bus.reg_rdata, 32'h20);
        rd(2'd1); chk("new_mask", bus.reg_rdata, 32'h5A);
        wr(2'd1, 32'h00);

        // Counter saturation and clear
        phase = "counter";
        wr(2'd1, 32'h01);
        wr(2'd3, 32'h0);
        for (int n = 0; n < int'(CMAX) + 4; n++) begin
            wr(2'd2, 32'h01);
            wr(2'd0, 32'h01);
        end
        rd(2'd3); chk("count_saturated", bus.reg_rdata, 32'(CMAX));
        wr(2'd3, 32'h1234);
        rd(2'd3); chk("count_cleared", bus.reg_rdata, 32'h0);

        // Random traffic with occasional mid-operation reset
        phase = "random";
        for (int n = 0; n < 1500; n++) begin
            logic r, w, rdd;
            logic [1:0] a;
            logic [31:0] d;
            r   = ($urandom_range(0, 99) < 2);
            w   = ($urandom_range(0, 99) < 40);
            rdd = ($urandom_range(0, 99) < 50);
            a   = 2'($urandom_range(0, 3));
            d   = $urandom;
            if ($urandom_range(0, 3) == 0) evt_lvl = 8'($urandom);
            step(r, w, rdd, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
